serial_lane_arbiter: RTL and testbench

Shares one word deserializer between `LANES` serial requesters. The block grants one lane at a time in round-robin order and shifts in exactly one word of a run-time width from that lane, LSB first. It then presents the word with its lane index on a valid/ready output port. It sits between the serial pin receivers and the word-level consumer (store/decode logic) and replaces per-lane deserializer instances.

---
 rtl/serial_lane_arbiter_pkg.sv | 32 +++
 rtl/serial_lane_arbiter_shifter.sv | 37 +++
 rtl/serial_lane_arbiter.sv | 131 +++++++++++++
 tb/tb_serial_lane_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_lane_arbiter_pkg.sv
// rtl/serial_lane_arbiter_pkg.sv - state type, width clamp and round-robin pick for serial_lane_arbiter
package serial_lane_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam int MAX_LANES = 8;
  localparam int CFG_BITS  = 7;

  function automatic logic [CFG_BITS-1:0] clamp_width(input logic [CFG_BITS-1:0] cfg,
                                                      input int max_width);
    if (cfg == '0 || int'(cfg) > max_width) return CFG_BITS'(max_width);
    return cfg;
  endfunction

  // Walk from the farthest lane back to last+1 so the nearest requester wins.
  function automatic logic [MAX_LANES-1:0] rr_pick(input logic [MAX_LANES-1:0] req,
                                                   input logic [2:0] last,
                                                   input int lanes);
    logic [MAX_LANES-1:0] grant;
    logic [2:0]           idx;
    grant = '0;
    for (int k = lanes; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % lanes);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/serial_lane_arbiter_shifter.sv
// rtl/serial_lane_arbiter_shifter.sv - lane_word_shifter: LSB-first word assembly with bit index
module lane_word_shifter
  #(
    parameter int MAX_WIDTH = 16,
    parameter int WB        = $clog2(MAX_WIDTH + 1)
  )
  (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic                 i_bit,
    input  logic [WB-1:0]        i_width,
    output logic [MAX_WIDTH-1:0] o_word,
    output logic                 o_last
  );

  logic [WB-1:0]        r_idx;
  logic [MAX_WIDTH-1:0] r_data;
  logic [MAX_WIDTH-1:0] w_bit_mask;

  // o_word already contains the bit being sampled, so the final bit is visible on the completing edge.
  assign w_bit_mask = MAX_WIDTH'(i_enable & i_bit) << r_idx;
  assign o_word     = r_data | w_bit_mask;
  assign o_last     = (r_idx == i_width - WB'(1));

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (i_enable) begin
      r_idx  <= r_idx + WB'(1);
      r_data <= o_word;
    end
  end

endmodule

// File: rtl/serial_lane_arbiter.sv
// rtl/serial_lane_arbiter.sv - round-robin shared deserializer; SERIAL_LANE_ARBITER_ABORT_EN discards frames whose request drops
module serial_lane_arbiter
  import serial_lane_arbiter_pkg::*;
  #(
    parameter int LANES     = 4,
    parameter int MAX_WIDTH = 16,
    parameter int WB        = $clog2(MAX_WIDTH + 1),
    parameter int LB        = $clog2(LANES)
  )
  (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [LANES-1:0]     i_req,
    input  logic [LANES-1:0]     i_serial_in,
    input  logic [WB-1:0]        i_cfg_width,
    output logic [LANES-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [MAX_WIDTH-1:0] o_out_data,
    output logic [LB-1:0]        o_out_lane
  );

  state_t               r_state, w_state_next;
  logic [LANES-1:0]     r_grant, w_pick;
  logic [LB-1:0]        r_lane, r_last, w_pick_idx;
  logic [WB-1:0]        r_w;
  logic                 r_out_valid;
  logic [MAX_WIDTH-1:0] r_out_data;
  logic [LB-1:0]        r_out_lane;
  logic                 w_clear, w_shift_en, w_done, w_abort, w_keep, w_last;
  logic [MAX_WIDTH-1:0] w_word;

  assign w_pick = LANES'(rr_pick(MAX_LANES'(i_req), 3'(r_last), LANES));

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_pick[k]) w_pick_idx = LB'(k);
    end
  end

`ifdef SERIAL_LANE_ARBITER_ABORT_EN
  assign w_keep = i_req[r_lane];
`else
  assign w_keep = 1'b1;
`endif

  lane_word_shifter #(.MAX_WIDTH(MAX_WIDTH), .WB(WB)) u_shifter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_enable(w_shift_en),
    .i_bit   (i_serial_in[r_lane]),
    .i_width (r_w),
    .o_word  (w_word),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_clear      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_keep) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_shift_en = 1'b1;
          if (w_last) begin
            w_done       = 1'b1;
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (r_out_valid && i_out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant     <= '0;
      r_lane      <= '0;
      r_last      <= LB'(LANES - 1);
      r_w         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
    end else begin
      if (w_clear) begin
        r_grant <= w_pick;
        r_lane  <= w_pick_idx;
        r_w     <= WB'(clamp_width(CFG_BITS'(i_cfg_width), MAX_WIDTH));
      end
      if (w_done || w_abort) begin
        r_grant <= '0;
        r_last  <= r_lane;
      end
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_lane  <= r_lane;
      end
      if (r_state == HOLD && r_out_valid && i_out_ready) r_out_valid <= 1'b0;
    end
  end

  assign o_grant     = r_grant;
  assign o_busy      = (r_state != IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_lane  = r_out_lane;

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// tb/tb_serial_lane_arbiter.sv - self-checking bench for serial_lane_arbiter
module tb_serial_lane_arbiter;
  localparam int LANES = 4;
  localparam int MW    = 16;
  localparam int WB    = 5;
  localparam int LB    = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [LANES-1:0] req, serial_in, grant;
  logic [WB-1:0]    cfg_width;
  logic             busy, out_valid, out_ready;
  logic [MW-1:0]    out_data;
  logic [LB-1:0]    out_lane;

  serial_lane_arbiter #(.LANES(LANES), .MAX_WIDTH(MW)) dut (
    .i_clock(clock), .i_reset(reset), .i_req(req), .i_serial_in(serial_in),
    .i_cfg_width(cfg_width), .o_grant(grant), .o_busy(busy), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_lane(out_lane)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int bitcnt = 0, gcount = 0;
  logic prev_g = 1'b0, prev_v = 1'b0, ev_new = 1'b0, ev_vrise = 1'b0;
  logic [MW-1:0] pat [LANES];
  logic [MW-1:0] cur_word [LANES];
  int cnt [LANES];

  typedef struct {
    logic [3:0]  req;
    logic [4:0]  cfg;
    logic [15:0] pat;
    logic [15:0] exp_data;
    int          exp_lane;
    int          exp_lat;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: observe at the falling edge, then play the granted lane's word bit by bit.
  task automatic tick();
    @(negedge clock);
    cyc++;
    ev_new   = (grant != 0) && !prev_g;
    ev_vrise = out_valid && !prev_v;
    prev_g   = (grant != 0);
    prev_v   = out_valid;
    if (ev_new) begin
      bitcnt = 0;
      gcount = 0;
    end
    serial_in = 4'($urandom);
    if (grant != 0) begin
      gcount++;
      for (int l = 0; l < LANES; l++)
        if (grant[l] && bitcnt < MW) serial_in[l] = pat[l][bitcnt];
      bitcnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_new(input string name);
    int n = 0;
    do begin tick(); n++; end while (!ev_new && n < 60);
    chk(name, {31'd0, ev_new}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic int clampw(input int c);
    return (c == 0 || c > MW) ? MW : c;
  endfunction

  function automatic logic [MW-1:0] wmask(input int w);
    return (w >= MW) ? {MW{1'b1}} : MW'((32'd1 << w) - 1);
  endfunction

  function automatic int rr_expect(input int last);
    for (int k = 1; k <= LANES; k++)
      if (cnt[(last + k) % LANES] > 0) return (last + k) % LANES;
    return -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, last_model, cur, any, stamp;
    int lanes_seen [5];
    int stamps [5];
    int cfgs [7];
    vec_t v;

    vecs[0] = '{4'b0001, 5'd8,  16'hFF4D, 16'h004D, 0, 9};
    vecs[1] = '{4'b0100, 5'd4,  16'hFFFA, 16'h000A, 2, 5};
    vecs[2] = '{4'b1010, 5'd0,  16'hFFFF, 16'hFFFF, 1, 17};
    vecs[3] = '{4'b1000, 5'd20, 16'h1234, 16'h1234, 3, 17};
    vecs[4] = '{4'b0110, 5'd1,  16'hFFFF, 16'h0001, 1, 2};
    vecs[5] = '{4'b1100, 5'd16, 16'hA5C3, 16'hA5C3, 2, 17};
    cfgs = '{0, 3, 7, 16, 20, 1, 5};

    serial_in = '0; cfg_width = 5'd8;
    do_reset();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_lane", 32'(out_lane), 32'd0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      do_reset();
      for (int l = 0; l < LANES; l++) pat[l] = v.pat;
      cfg_width = v.cfg;
      req = v.req;
      lat = 0;
      do begin tick(); lat++; end while (!out_valid && lat < 40);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(v.exp_data));
      chk($sformatf("vec%0d_lane", i), 32'(out_lane), 32'(v.exp_lane));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      req = '0;
      handshake();
      chk($sformatf("vec%0d_valid_clear", i), {31'd0, out_valid}, 32'd0);
    end

    // Round robin with all lanes requesting and the consumer always ready.
    do_reset();
    cfg_width = 5'd4; out_ready = 1'b1; req = 4'b1111;
    for (int l = 0; l < LANES; l++) pat[l] = 16'($urandom);
    for (int k = 0; k < 5; k++) begin
      wait_new($sformatf("rr_grant%0d_seen", k));
      stamps[k] = cyc;
      lanes_seen[k] = -1;
      for (int l = 0; l < LANES; l++) if (grant[l]) lanes_seen[k] = l;
      chk($sformatf("rr_lane%0d", k), 32'(lanes_seen[k]), 32'(k % LANES));
      if (k > 0) chk($sformatf("rr_period%0d", k), 32'(stamps[k] - stamps[k-1]), 32'd6);
    end

    // Backpressure: word held stable, lane 2 waits for the handshake.
    do_reset();
    cfg_width = 5'd4; req = 4'b0001; pat[0] = 16'h0009;
    wait_new("bp_grant0");
    req = 4'b0101;
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_data%0d", k), 32'(out_data), 32'h0009);
      chk($sformatf("bp_lane%0d", k), 32'(out_lane), 32'd0);
      chk($sformatf("bp_busy%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("bp_grant%0d", k), 32'(grant), 32'd0);
    end
    out_ready = 1'b1; req = 4'b0100;
    tick();
    out_ready = 1'b0;
    chk("bp_no_grant_at_handshake", 32'(grant), 32'd0);
    chk("bp_data_after_hs", 32'(out_data), 32'h0009);
    tick();
    chk("bp_lane2_grant", 32'(grant), 32'b0100);

    // Reset in the middle of a frame.
    do_reset();
    cfg_width = 5'd8; req = 4'b1000; pat[3] = 16'h00A7;
    wait_valid("mr_first_valid");
    req = '0;
    handshake();
    req = 4'b0010; pat[1] = 16'h00FF;
    wait_new("mr_grant1");
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 4'b0011;
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_lane", 32'(out_lane), 32'd0);
    wait_new("mr_regrant");
    chk("mr_first_lane0", 32'(grant), 32'b0001);

    // Request drop on the granted lane at bit 2.
    do_reset();
    cfg_width = 5'd8; req = 4'b0110; pat[1] = 16'h00C5; pat[2] = 16'h0033;
    wait_new("ab_grant");
    chk("ab_lane1", 32'(grant), 32'b0010);
    tick(); tick();
    req = 4'b0100;
`ifdef SERIAL_LANE_ARBITER_ABORT_EN
    tick();
    chk("ab_grant_off", 32'(grant), 32'd0);
    chk("ab_no_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("ab_next_lane2", 32'(grant), 32'b0100);
`else
    wait_valid("ab_valid");
    chk("ab_lane", 32'(out_lane), 32'd1);
    chk("ab_data", 32'(out_data), 32'h00C5);
    handshake();
    tick();
    chk("ab_next_lane2", 32'(grant), 32'b0100);
`endif

    // Random traffic checked against a transaction-level model.
    do_reset();
    last_model = LANES - 1;
    cur = -1;
    for (int s = 0; s < 7; s++) begin
      cfg_width = WB'(cfgs[s]);
      for (int l = 0; l < LANES; l++) begin
        cnt[l] = $urandom_range(0, 3);
        cur_word[l] = 16'($urandom);
        pat[l] = cur_word[l];
        req[l] = (cnt[l] > 0);
      end
      stamp = 0;
      any = 0;
      for (int l = 0; l < LANES; l++) any += cnt[l];
      while (any > 0 && stamp < 3000) begin
        tick();
        stamp++;
        out_ready = $urandom_range(0, 1);
        if (ev_new) begin
          cur = rr_expect(last_model);
          chk("rand_grant", 32'(grant), (cur < 0) ? 32'd0 : (32'd1 << cur));
        end
        if (ev_vrise && cur >= 0) begin
          chk("rand_lane", 32'(out_lane), 32'(cur));
          chk("rand_data", 32'(out_data), 32'(cur_word[cur] & wmask(clampw(cfgs[s]))));
          chk("rand_bits", 32'(gcount), 32'(clampw(cfgs[s])));
          last_model = cur;
        end
        if (out_valid && out_ready && cur >= 0) begin
          cnt[cur]--;
          cur_word[cur] = 16'($urandom);
          pat[cur] = cur_word[cur];
          req[cur] = (cnt[cur] > 0);
          any--;
        end
      end
      chk("rand_drained", 32'(any), 32'd0);
      tick();
      out_ready = 1'b0;
      chk("rand_idle", {31'd0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
